dma_slice_2d: RTL and testbench

//  Next-generation DMA slice engine. Turns one descriptor into a stream of AXI

---
 rtl/dma_slice_2d_pkg.sv | 34 +++
 rtl/dma_slice_2d_burst_calc.sv | 86 ++++++++
 rtl/dma_slice_2d.sv | 250 +++++++++++++++++++++++++
 tb/tb_dma_slice_2d.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_slice_2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and helpers for the 2D DMA slice engine.
//               FSM state encoding, beat-size helpers and the 4KB page
//               constants used by the burst splitter.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALC     = 3'd1,
        ISSUE    = 3'd2,
        NEXT_ROW = 3'd3,
        DONE     = 3'd4
    } dma_state_e;

    // AXI bursts must never cross a 4KB page
    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_BITS  = 12;

    // Bytes per data beat for a given bus width
    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // log2(bytes per beat); doubles as the AXI AxSIZE encoding
    function automatic int beat_size(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_slice_2d_burst_calc.sv
`default_nettype none
// ============================================================================
// Module      : dma_burst_calc
// Description : Combinational burst splitter. From the current address and
//               remaining row bytes, picks either a single partial beat
//               (unaligned head, short tail, or jump mode) or the largest
//               full-beat burst limited by maxburst and the 4KB page.
// Ports       : cur      - current byte address
//               remain   - bytes left in the current row
//               mode     - 1 forces single beats (jump mode)
//               maxburst - beat limit, 0 treated as 1
//               alen     - beats-1 for the request
//               strb     - byte lanes of a single beat, all ones for bursts
//               send     - bytes consumed by this request
//               last_row - this request finishes the row
// Revision    : 1.0 - initial release
// ============================================================================
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int DMA_ADDR_WIDTH  = 32,
    parameter int DMA_DATA_WIDTH  = 64,
    parameter int DMA_BYTES_WIDTH = 32
) (
    input  logic [DMA_ADDR_WIDTH-1:0]   cur,
    input  logic [DMA_BYTES_WIDTH-1:0]  remain,
    input  logic                        mode,
    input  logic [7:0]                  maxburst,
    output logic [7:0]                  alen,
    output logic [DMA_DATA_WIDTH/8-1:0] strb,
    output logic [DMA_BYTES_WIDTH-1:0]  send,
    output logic                        last_row
);

    localparam int B    = beat_bytes(DMA_DATA_WIDTH);
    localparam int OFFW = beat_size(DMA_DATA_WIDTH);
    localparam int NW   = OFFW + 1;
    localparam int PW   = PAGE_BITS + 1;
    localparam int BW   = DMA_BYTES_WIDTH;

    logic [OFFW-1:0] off;
    logic [NW-1:0]   room;
    logic [BW-1:0]   room_ext;
    logic [BW-1:0]   n_bytes;
    logic [BW-1:0]   rem_beats;
    logic [BW-1:0]   mb_eff;
    logic [PW-1:0]   page_left;
    logic [BW-1:0]   page_beats;
    logic [BW-1:0]   beats;
    logic            single;

    always_comb begin
        off        = cur[OFFW-1:0];
        room       = NW'(B) - NW'(off);
        room_ext   = BW'(room);
        single     = (off != '0) || (remain < BW'(B)) || mode;
        n_bytes    = (remain < room_ext) ? remain : room_ext;

        // Burst length is the tightest of three limits; all are >= 1 on the
        // burst path because the address is aligned and remain >= B there.
        rem_beats  = remain >> OFFW;
        mb_eff     = (maxburst == 8'd0) ? BW'(1) : BW'(maxburst);
        page_left  = PW'(PAGE_BYTES) - PW'(cur[PAGE_BITS-1:0]);
        page_beats = BW'(page_left >> OFFW);
        beats      = mb_eff;
        if (rem_beats < beats) beats = rem_beats;
        if (page_beats < beats) beats = page_beats;

        alen = 8'd0;
        strb = '0;
        send = '0;
        if (single) begin
            send = n_bytes;
            for (int i = 0; i < B; i++) begin
                strb[i] = (i >= int'(off)) && (i < int'(off) + int'(n_bytes));
            end
        end else begin
            alen = 8'(beats - BW'(1));
            strb = '1;
            send = beats << OFFW;
        end
        last_row = (send == remain);
    end

endmodule
`default_nettype wire

// File: rtl/dma_slice_2d.sv
`default_nettype none
// ============================================================================
// Module      : dma_slice_2d
// Description : DMA slice engine. Converts one descriptor (optionally 2D:
//               rows x stride) into a sequence of AXI address requests,
//               one outstanding at a time, never crossing a 4KB page.
// Ports       : clk, rst_n           - clock, async active-low reset
//               csr_desc_*           - descriptor table (per-index arrays)
//               csr_dma_maxburst     - max beats per burst (0 -> 1)
//               dma_axi_req_*        - request channel to the AXI master
//               dma_slice_idx/valid  - start a slice on descriptor idx
//               dma_slice_ready      - engine idle
//               dma_slice_done       - one-cycle completion pulse
// Config      : DMA_SLICE_ABORT_EN adds dma_slice_abort (in) and
//               dma_slice_aborted (out, high with the done pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module dma_slice_2d
    import dma_pkg::*;
#(
    parameter int DMA_ADDR_WIDTH  = 32,
    parameter int DMA_DATA_WIDTH  = 64,
    parameter int DMA_BYTES_WIDTH = 32,
    parameter int DMA_ROWS_WIDTH  = 16,
    parameter int DMA_NUM_DESC    = 8,
    localparam int AXI_STRB_WIDTH = DMA_DATA_WIDTH / 8,
    localparam int DESC_IDX_WIDTH = (DMA_NUM_DESC > 1) ? $clog2(DMA_NUM_DESC) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DMA_ADDR_WIDTH-1:0]  csr_desc_addr       [DMA_NUM_DESC],
    input  logic                       csr_desc_mode       [DMA_NUM_DESC],
    input  logic [DMA_BYTES_WIDTH-1:0] csr_desc_num_bytes  [DMA_NUM_DESC],
    input  logic [DMA_BYTES_WIDTH-1:0] csr_desc_jump_bytes [DMA_NUM_DESC],
    input  logic [DMA_ROWS_WIDTH-1:0]  csr_desc_rows       [DMA_NUM_DESC],
    input  logic [DMA_BYTES_WIDTH-1:0] csr_desc_row_stride [DMA_NUM_DESC],
    input  logic [7:0]                 csr_dma_maxburst,
    output logic                       dma_axi_req_valid,
    input  logic                       dma_axi_req_ready,
    output logic [DMA_ADDR_WIDTH-1:0]  dma_axi_req_addr,
    output logic [AXI_STRB_WIDTH-1:0]  dma_axi_req_strb,
    output logic [2:0]                 dma_axi_req_size,
    output logic [7:0]                 dma_axi_req_alen,
    output logic                       dma_axi_req_last,
    input  logic [DESC_IDX_WIDTH-1:0]  dma_slice_idx,
    input  logic                       dma_slice_valid,
`ifdef DMA_SLICE_ABORT_EN
    input  logic                       dma_slice_abort,
    output logic                       dma_slice_aborted,
`endif
    output logic                       dma_slice_ready,
    output logic                       dma_slice_done
);

    localparam int AW   = DMA_ADDR_WIDTH;
    localparam int BW   = DMA_BYTES_WIDTH;
    localparam int RW   = DMA_ROWS_WIDTH;
    localparam int B    = beat_bytes(DMA_DATA_WIDTH);
    localparam int OFFW = beat_size(DMA_DATA_WIDTH);

    dma_state_e          state_q, state_d;
    logic [AW-1:0]       cur_q, cur_d;
    logic [AW-1:0]       row_q, row_d;
    logic [BW-1:0]       remain_q, remain_d;
    logic [RW-1:0]       rows_left_q, rows_left_d;
    // Descriptor snapshot: CSR writes mid-slice must not disturb the slice
    logic                mode_q, mode_d;
    logic [BW-1:0]       num_bytes_q, num_bytes_d;
    logic [BW-1:0]       jump_q, jump_d;
    logic [BW-1:0]       stride_q, stride_d;
    logic [7:0]          maxburst_q, maxburst_d;
    logic                req_valid_q, req_valid_d;
    logic [AW-1:0]       req_addr_q, req_addr_d;
    logic [AXI_STRB_WIDTH-1:0] req_strb_q, req_strb_d;
    logic [7:0]          req_alen_q, req_alen_d;
    logic                req_last_q, req_last_d;
    logic [BW-1:0]       send_q, send_d;
    logic                aborted_q, aborted_d;

    logic                abort_req;
    logic [7:0]          calc_alen;
    logic [AXI_STRB_WIDTH-1:0] calc_strb;
    logic [BW-1:0]       calc_send;
    logic                calc_last_row;

`ifdef DMA_SLICE_ABORT_EN
    assign abort_req         = dma_slice_abort;
    assign dma_slice_aborted = aborted_q && (state_q == DONE);
`else
    assign abort_req         = 1'b0;
`endif

    dma_burst_calc #(
        .DMA_ADDR_WIDTH  (AW),
        .DMA_DATA_WIDTH  (DMA_DATA_WIDTH),
        .DMA_BYTES_WIDTH (BW)
    ) u_burst_calc (
        .cur      (cur_q),
        .remain   (remain_q),
        .mode     (mode_q),
        .maxburst (maxburst_q),
        .alen     (calc_alen),
        .strb     (calc_strb),
        .send     (calc_send),
        .last_row (calc_last_row)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        row_d       = row_q;
        remain_d    = remain_q;
        rows_left_d = rows_left_q;
        mode_d      = mode_q;
        num_bytes_d = num_bytes_q;
        jump_d      = jump_q;
        stride_d    = stride_q;
        maxburst_d  = maxburst_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_strb_d  = req_strb_q;
        req_alen_d  = req_alen_q;
        req_last_d  = req_last_q;
        send_d      = send_q;
        aborted_d   = aborted_q;

        case (state_q)
            IDLE: begin
                if (dma_slice_valid) begin
                    cur_d       = csr_desc_addr[dma_slice_idx];
                    row_d       = csr_desc_addr[dma_slice_idx];
                    remain_d    = csr_desc_num_bytes[dma_slice_idx];
                    rows_left_d = csr_desc_rows[dma_slice_idx];
                    mode_d      = csr_desc_mode[dma_slice_idx];
                    num_bytes_d = csr_desc_num_bytes[dma_slice_idx];
                    jump_d      = csr_desc_jump_bytes[dma_slice_idx];
                    stride_d    = csr_desc_row_stride[dma_slice_idx];
                    maxburst_d  = csr_dma_maxburst;
                    aborted_d   = 1'b0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                if (abort_req) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if ((remain_q == '0) || (rows_left_q == '0)) begin
                    // Empty descriptor: finish without any request
                    state_d = DONE;
                end else begin
                    req_valid_d = 1'b1;
                    req_addr_d  = cur_q & ~AW'(B - 1);
                    req_strb_d  = calc_strb;
                    req_alen_d  = calc_alen;
                    req_last_d  = calc_last_row && (rows_left_q == RW'(1));
                    send_d      = calc_send;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // An abort here never withdraws the request; it is remembered
                // and honoured once the handshake completes.
                aborted_d = aborted_q || abort_req;
                if (dma_axi_req_ready) begin
                    req_valid_d = 1'b0;
                    remain_d    = remain_q - send_q;
                    cur_d       = cur_q + (mode_q ? AW'(jump_q) : AW'(send_q));
                    if (aborted_d) begin
                        state_d = DONE;
                    end else if (remain_d != '0) begin
                        state_d = CALC;
                    end else if (rows_left_q > RW'(1)) begin
                        state_d = NEXT_ROW;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            NEXT_ROW: begin
                if (abort_req) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    row_d       = row_q + AW'(stride_q);
                    cur_d       = row_q + AW'(stride_q);
                    remain_d    = num_bytes_q;
                    rows_left_d = rows_left_q - RW'(1);
                    state_d     = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            row_q       <= '0;
            remain_q    <= '0;
            rows_left_q <= '0;
            mode_q      <= 1'b0;
            num_bytes_q <= '0;
            jump_q      <= '0;
            stride_q    <= '0;
            maxburst_q  <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_strb_q  <= '0;
            req_alen_q  <= '0;
            req_last_q  <= 1'b0;
            send_q      <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            row_q       <= row_d;
            remain_q    <= remain_d;
            rows_left_q <= rows_left_d;
            mode_q      <= mode_d;
            num_bytes_q <= num_bytes_d;
            jump_q      <= jump_d;
            stride_q    <= stride_d;
            maxburst_q  <= maxburst_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_strb_q  <= req_strb_d;
            req_alen_q  <= req_alen_d;
            req_last_q  <= req_last_d;
            send_q      <= send_d;
            aborted_q   <= aborted_d;
        end
    end

    assign dma_axi_req_valid = req_valid_q;
    assign dma_axi_req_addr  = req_addr_q;
    assign dma_axi_req_strb  = req_strb_q;
    assign dma_axi_req_alen  = req_alen_q;
    assign dma_axi_req_last  = req_last_q;
    assign dma_axi_req_size  = 3'(OFFW);
    assign dma_slice_ready   = (state_q == IDLE);
    assign dma_slice_done    = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_dma_slice_2d.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_slice_2d
// Description : Self-checking bench for dma_slice_2d (64-bit bus, B = 8).
//               Descriptor vectors from a table; expected requests are
//               queued when a slice starts and popped on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dma_slice_2d;

    localparam int AW = 32, DW = 64, BW = 32, RW = 16, ND = 8;
    localparam int NV = 12, NE = 23;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [7:0]  strb;
        logic        last;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] bytes;
        logic [31:0] jump;
        logic [15:0] rows;
        logic [31:0] stride;
        logic        mode;
        logic [7:0]  mb;
        int          first;
        int          nexp;
        int          stall_req;
        int          stall_cyc;
        bit          hold;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] csr_desc_addr       [ND];
    logic          csr_desc_mode       [ND];
    logic [BW-1:0] csr_desc_num_bytes  [ND];
    logic [BW-1:0] csr_desc_jump_bytes [ND];
    logic [RW-1:0] csr_desc_rows       [ND];
    logic [BW-1:0] csr_desc_row_stride [ND];
    logic [7:0]    csr_dma_maxburst;
    logic          dma_axi_req_valid;
    logic          dma_axi_req_ready;
    logic [AW-1:0] dma_axi_req_addr;
    logic [7:0]    dma_axi_req_strb;
    logic [2:0]    dma_axi_req_size;
    logic [7:0]    dma_axi_req_alen;
    logic          dma_axi_req_last;
    logic [2:0]    dma_slice_idx;
    logic          dma_slice_valid;
    logic          dma_slice_ready;
    logic          dma_slice_done;
`ifdef DMA_SLICE_ABORT_EN
    logic          dma_slice_abort;
    logic          dma_slice_aborted;
`endif

    int   total = 0;
    int   bad   = 0;
    req_t exp_tab [NE];
    vec_t vecs    [NV];
    req_t exp_q   [$];

    always #5 clk = ~clk;

    dma_slice_2d #(
        .DMA_ADDR_WIDTH  (AW),
        .DMA_DATA_WIDTH  (DW),
        .DMA_BYTES_WIDTH (BW),
        .DMA_ROWS_WIDTH  (RW),
        .DMA_NUM_DESC    (ND)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .csr_desc_addr       (csr_desc_addr),
        .csr_desc_mode       (csr_desc_mode),
        .csr_desc_num_bytes  (csr_desc_num_bytes),
        .csr_desc_jump_bytes (csr_desc_jump_bytes),
        .csr_desc_rows       (csr_desc_rows),
        .csr_desc_row_stride (csr_desc_row_stride),
        .csr_dma_maxburst    (csr_dma_maxburst),
        .dma_axi_req_valid   (dma_axi_req_valid),
        .dma_axi_req_ready   (dma_axi_req_ready),
        .dma_axi_req_addr    (dma_axi_req_addr),
        .dma_axi_req_strb    (dma_axi_req_strb),
        .dma_axi_req_size    (dma_axi_req_size),
        .dma_axi_req_alen    (dma_axi_req_alen),
        .dma_axi_req_last    (dma_axi_req_last),
        .dma_slice_idx       (dma_slice_idx),
        .dma_slice_valid     (dma_slice_valid),
`ifdef DMA_SLICE_ABORT_EN
        .dma_slice_abort     (dma_slice_abort),
        .dma_slice_aborted   (dma_slice_aborted),
`endif
        .dma_slice_ready     (dma_slice_ready),
        .dma_slice_done      (dma_slice_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_req(input string tag, input req_t e);
        chk({tag, "_addr"}, 64'(dma_axi_req_addr), 64'(e.addr));
        chk({tag, "_alen"}, 64'(dma_axi_req_alen), 64'(e.alen));
        chk({tag, "_strb"}, 64'(dma_axi_req_strb), 64'(e.strb));
        chk({tag, "_last"}, 64'(dma_axi_req_last), 64'(e.last));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, nreq, stall_n, last_hs;
        bit seen_done, prev_valid;
        csr_desc_addr[idx]       = v.addr;
        csr_desc_num_bytes[idx]  = v.bytes;
        csr_desc_jump_bytes[idx] = v.jump;
        csr_desc_rows[idx]       = v.rows;
        csr_desc_row_stride[idx] = v.stride;
        csr_desc_mode[idx]       = v.mode;
        csr_dma_maxburst         = v.mb;
        dma_axi_req_ready        = 1'b1;
        for (int k = 0; k < v.nexp; k++) exp_q.push_back(exp_tab[v.first + k]);
        dma_slice_idx   = 3'(idx);
        dma_slice_valid = 1'b1;
        tick();
        if (!v.hold) dma_slice_valid = 1'b0;
        // The slice must ignore descriptor edits after acceptance
        csr_desc_addr[idx]      = ~v.addr;
        csr_desc_num_bytes[idx] = v.bytes + 32'd8;
        csr_desc_rows[idx]      = v.rows + 16'd1;
        csr_desc_mode[idx]      = ~v.mode;
        csr_dma_maxburst        = 8'd3;
        cyc = 1; nreq = 0; stall_n = 0; last_hs = -10;
        seen_done = 1'b0; prev_valid = 1'b0;
        chk("ready_busy", 64'(dma_slice_ready), 64'd0);
        while (!seen_done && cyc < 300) begin
            if (dma_slice_done) begin
                seen_done = 1'b1;
                dma_slice_valid = 1'b0;
                if (v.nexp == 0) chk("done_lat_empty", 64'(cyc), 64'd2);
                else             chk("done_after_hs", 64'(cyc - last_hs), 64'd1);
            end else if (dma_axi_req_valid) begin
                if (!prev_valid && nreq == 0) chk("first_lat", 64'(cyc), 64'd2);
                if (!prev_valid && nreq > 0)  chk("spacing_ge2", 64'(cyc - last_hs >= 2), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("extra_req", 64'(dma_axi_req_valid), 64'd0);
                    dma_axi_req_ready = 1'b1;
                    last_hs = cyc;
                end else begin
                    check_req($sformatf("v%0d_r%0d", idx, nreq), exp_q[0]);
                    if (nreq == v.stall_req && stall_n < v.stall_cyc) begin
                        dma_axi_req_ready = 1'b0;
                        stall_n++;
                    end else begin
                        dma_axi_req_ready = 1'b1;
                        void'(exp_q.pop_front());
                        nreq++;
                        last_hs = cyc;
                    end
                end
            end
            prev_valid = dma_axi_req_valid;
            if (!seen_done) begin
                tick();
                cyc++;
            end
        end
        chk("done_seen", 64'(seen_done), 64'd1);
        chk("reqs_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
        chk("done_pulse_1cyc", 64'(dma_slice_done), 64'd0);
        chk("ready_after", 64'(dma_slice_ready), 64'd1);
        chk("no_req_after", 64'(dma_axi_req_valid), 64'd0);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!dma_axi_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_seen"}, 64'(dma_axi_req_valid), 64'd1);
    endtask

    initial begin
        rst_n             = 1'b0;
        dma_axi_req_ready = 1'b1;
        dma_slice_valid   = 1'b0;
        dma_slice_idx     = '0;
        csr_dma_maxburst  = 8'd16;
`ifdef DMA_SLICE_ABORT_EN
        dma_slice_abort   = 1'b0;
`endif
        for (int i = 0; i < ND; i++) begin
            csr_desc_addr[i] = '0; csr_desc_mode[i] = 1'b0; csr_desc_num_bytes[i] = '0;
            csr_desc_jump_bytes[i] = '0; csr_desc_rows[i] = '0; csr_desc_row_stride[i] = '0;
        end

        exp_tab[0]  = '{32'h0000_1000, 8'd7,  8'hFF, 1'b1};
        exp_tab[1]  = '{32'h0000_0FF8, 8'd0,  8'hE0, 1'b0};
        exp_tab[2]  = '{32'h0000_1000, 8'd1,  8'hFF, 1'b0};
        exp_tab[3]  = '{32'h0000_1010, 8'd0,  8'h01, 1'b1};
        exp_tab[4]  = '{32'h0000_0FC0, 8'd7,  8'hFF, 1'b0};
        exp_tab[5]  = '{32'h0000_1000, 8'd23, 8'hFF, 1'b1};
        exp_tab[6]  = '{32'h0000_2000, 8'd1,  8'hFF, 1'b0};
        exp_tab[7]  = '{32'h0000_2100, 8'd1,  8'hFF, 1'b0};
        exp_tab[8]  = '{32'h0000_2200, 8'd1,  8'hFF, 1'b1};
        exp_tab[9]  = '{32'h0000_3000, 8'd0,  8'hFF, 1'b0};
        exp_tab[10] = '{32'h0000_3040, 8'd0,  8'hFF, 1'b0};
        exp_tab[11] = '{32'h0000_3080, 8'd0,  8'hFF, 1'b1};
        exp_tab[12] = '{32'h0000_4000, 8'd0,  8'hFF, 1'b0};
        exp_tab[13] = '{32'h0000_4008, 8'd0,  8'hFF, 1'b1};
        exp_tab[14] = '{32'h0000_5000, 8'd3,  8'hFF, 1'b0};
        exp_tab[15] = '{32'h0000_5020, 8'd1,  8'hFF, 1'b1};
        exp_tab[16] = '{32'h0000_6000, 8'd0,  8'h18, 1'b1};
        exp_tab[17] = '{32'hFFFF_FFF8, 8'd0,  8'hFF, 1'b0};
        exp_tab[18] = '{32'h0000_0000, 8'd0,  8'hFF, 1'b1};
        exp_tab[19] = '{32'h0000_7000, 8'd0,  8'hE0, 1'b0};
        exp_tab[20] = '{32'h0000_7008, 8'd0,  8'h01, 1'b0};
        exp_tab[21] = '{32'h0000_7010, 8'd0,  8'hE0, 1'b0};
        exp_tab[22] = '{32'h0000_7018, 8'd0,  8'h01, 1'b1};

        //              addr          bytes  jump    rows   stride  md  mb    first n  stall cyc hold
        vecs[0]  = '{32'h0000_1000, 32'd64,  32'h0,  16'd1, 32'h0,   1'b0, 8'd16,  0, 1, -1, 0, 1'b0};
        vecs[1]  = '{32'h0000_0FFD, 32'd20,  32'h0,  16'd1, 32'h0,   1'b0, 8'd16,  1, 3,  0, 2, 1'b0};
        vecs[2]  = '{32'h0000_0FC0, 32'd256, 32'h0,  16'd1, 32'h0,   1'b0, 8'd255, 4, 2, -1, 0, 1'b0};
        vecs[3]  = '{32'h0000_2000, 32'd16,  32'h0,  16'd3, 32'h100, 1'b0, 8'd16,  6, 3, -1, 0, 1'b1};
        vecs[4]  = '{32'h0000_3000, 32'd24,  32'h40, 16'd1, 32'h0,   1'b1, 8'd16,  9, 3,  1, 5, 1'b0};
        vecs[5]  = '{32'h0000_4000, 32'd16,  32'h0,  16'd1, 32'h0,   1'b0, 8'd0,  12, 2, -1, 0, 1'b0};
        vecs[6]  = '{32'h0000_5000, 32'h30,  32'h0,  16'd1, 32'h0,   1'b0, 8'd4,  14, 2, -1, 0, 1'b0};
        vecs[7]  = '{32'h0000_6003, 32'd2,   32'h0,  16'd1, 32'h0,   1'b0, 8'd16, 16, 1, -1, 0, 1'b0};
        vecs[8]  = '{32'h0000_9000, 32'd0,   32'h0,  16'd1, 32'h0,   1'b0, 8'd16,  0, 0, -1, 0, 1'b0};
        vecs[9]  = '{32'h0000_9000, 32'd16,  32'h0,  16'd0, 32'h0,   1'b0, 8'd16,  0, 0, -1, 0, 1'b0};
        vecs[10] = '{32'hFFFF_FFF8, 32'd16,  32'h0,  16'd1, 32'h0,   1'b0, 8'd16, 17, 2, -1, 0, 1'b0};
        vecs[11] = '{32'h0000_7005, 32'd4,   32'h0,  16'd2, 32'h10,  1'b0, 8'd16, 19, 4, -1, 0, 1'b0};

        repeat (3) tick();
        chk("rst_valid", 64'(dma_axi_req_valid), 64'd0);
        chk("rst_done",  64'(dma_slice_done),    64'd0);
        chk("rst_addr",  64'(dma_axi_req_addr),  64'd0);
        chk("rst_alen",  64'(dma_axi_req_alen),  64'd0);
        chk("rst_strb",  64'(dma_axi_req_strb),  64'd0);
        chk("rst_last",  64'(dma_axi_req_last),  64'd0);
        chk("rst_size",  64'(dma_axi_req_size),  64'd3);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < NV; v++) run_vec(vecs[v], v % ND);

`ifdef DMA_SLICE_ABORT_EN
        // Abort while the second single-beat request is stalled
        csr_desc_addr[0] = 32'h8000; csr_desc_num_bytes[0] = 32'd64; csr_desc_rows[0] = 16'd1;
        csr_desc_mode[0] = 1'b0; csr_dma_maxburst = 8'd1; dma_slice_idx = 3'd0;
        dma_axi_req_ready = 1'b1;
        dma_slice_valid = 1'b1; tick(); dma_slice_valid = 1'b0;
        wait_valid("ab_r0");
        chk("ab_r0_addr", 64'(dma_axi_req_addr), 64'h8000);
        tick();
        wait_valid("ab_r1");
        chk("ab_r1_addr", 64'(dma_axi_req_addr), 64'h8008);
        dma_axi_req_ready = 1'b0;
        tick(); tick();
        dma_slice_abort = 1'b1; tick(); dma_slice_abort = 1'b0; tick();
        chk("ab_hold_valid", 64'(dma_axi_req_valid), 64'd1);
        chk("ab_hold_addr",  64'(dma_axi_req_addr),  64'h8008);
        chk("ab_no_done",    64'(dma_slice_done),    64'd0);
        dma_axi_req_ready = 1'b1;
        tick();
        chk("ab_done",    64'(dma_slice_done),    64'd1);
        chk("ab_aborted", 64'(dma_slice_aborted), 64'd1);
        chk("ab_valid",   64'(dma_axi_req_valid), 64'd0);
        tick();
        chk("ab_idle",    64'(dma_slice_ready),   64'd1);
        chk("ab_clear",   64'(dma_slice_aborted), 64'd0);
`endif

        // Reset in the middle of a slice drops everything silently
        csr_desc_addr[1] = 32'hA000; csr_desc_num_bytes[1] = 32'd64; csr_desc_rows[1] = 16'd1;
        csr_desc_mode[1] = 1'b0; csr_dma_maxburst = 8'd1; dma_slice_idx = 3'd1;
        dma_axi_req_ready = 1'b0;
        dma_slice_valid = 1'b1; tick(); dma_slice_valid = 1'b0;
        tick();
        chk("mid_valid_before", 64'(dma_axi_req_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 64'(dma_axi_req_valid), 64'd0);
        chk("mid_rst_done",  64'(dma_slice_done),    64'd0);
        tick();
        rst_n = 1'b1;
        dma_axi_req_ready = 1'b1;
        tick(); tick();
        chk("mid_rst_ready", 64'(dma_slice_ready),   64'd1);
        chk("mid_rst_quiet", 64'(dma_axi_req_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
